// File: rtl/ysyx_22041071_axi_w.sv
// AXI4 write-channel master: one outstanding AW -> W beats -> B transaction, with
// sub-word lane alignment. Optional BID check enabled by YSYX_22041071_AXI_W_BID_CHECK_EN.

`ifndef ysyx_22041071_AXI_DATA_WIDTH
`define ysyx_22041071_AXI_DATA_WIDTH 64
`endif
`ifndef ysyx_22041071_AXI_ADDR_WIDTH
`define ysyx_22041071_AXI_ADDR_WIDTH 64
`endif
`ifndef ysyx_22041071_AXI_ID_WIDTH
`define ysyx_22041071_AXI_ID_WIDTH 4
`endif
`ifndef ysyx_22041071_AXI_LEN_WIDTH
`define ysyx_22041071_AXI_LEN_WIDTH 8
`endif

module ysyx_22041071_axi_w (
    input  logic                                       clk,
    input  logic                                       reset,

    input  logic                                       cpu_aw_valid,
    output logic                                       cpu_aw_ready,
    input  logic [`ysyx_22041071_AXI_ID_WIDTH-1:0]     cpu_id,
    input  logic [`ysyx_22041071_AXI_ADDR_WIDTH-1:0]   cpu_addr,
    input  logic [`ysyx_22041071_AXI_LEN_WIDTH-1:0]    cpu_len,
    input  logic [1:0]                                 cpu_size,
    input  logic                                       cpu_w_valid,
    output logic                                       cpu_w_ready,
    input  logic [`ysyx_22041071_AXI_DATA_WIDTH-1:0]   cpu_w_data,
    output logic                                       cpu_b_valid,
    output logic [1:0]                                 cpu_b_resp,

    output logic                                       axi_aw_valid_o,
    input  logic                                       axi_aw_ready_i,
    output logic [`ysyx_22041071_AXI_ID_WIDTH-1:0]     axi_aw_id_o,
    output logic [`ysyx_22041071_AXI_ADDR_WIDTH-1:0]   axi_aw_addr_o,
    output logic [`ysyx_22041071_AXI_LEN_WIDTH-1:0]    axi_aw_len_o,
    output logic [2:0]                                 axi_aw_size_o,
    output logic [1:0]                                 axi_aw_burst_o,
    output logic [2:0]                                 axi_aw_prot_o,
    output logic                                       axi_aw_user_o,
    output logic                                       axi_aw_lock_o,
    output logic [3:0]                                 axi_aw_cache_o,
    output logic [3:0]                                 axi_aw_qos_o,
    output logic [3:0]                                 axi_aw_region_o,

    output logic                                       axi_w_valid_o,
    input  logic                                       axi_w_ready_i,
    output logic [`ysyx_22041071_AXI_DATA_WIDTH-1:0]   axi_w_data_o,
    output logic [`ysyx_22041071_AXI_DATA_WIDTH/8-1:0] axi_w_strb_o,
    output logic                                       axi_w_last_o,
    output logic                                       axi_w_user_o,

    input  logic                                       axi_b_valid_i,
    output logic                                       axi_b_ready_o,
    input  logic [1:0]                                 axi_b_resp_i,
    input  logic [`ysyx_22041071_AXI_ID_WIDTH-1:0]     axi_b_id_i,
    input  logic                                       axi_b_user_i
);

    localparam int unsigned DataW = `ysyx_22041071_AXI_DATA_WIDTH;
    localparam int unsigned AddrW = `ysyx_22041071_AXI_ADDR_WIDTH;
    localparam int unsigned IdW   = `ysyx_22041071_AXI_ID_WIDTH;
    localparam int unsigned LenW  = `ysyx_22041071_AXI_LEN_WIDTH;
    localparam int unsigned StrbW = DataW / 8;
    localparam int unsigned OffW  = $clog2(StrbW);

    typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_e;

    state_e            state_q, state_d;
    logic [IdW-1:0]    id_q;
    logic [AddrW-1:0]  addr_q;
    logic [LenW-1:0]   len_q;
    logic [1:0]        size_q;
    logic [LenW-1:0]   beat_cnt_q;
    logic              b_valid_q;
    logic [1:0]        b_resp_q, b_resp_d;

    logic              req_accept;
    logic              aw_fire;
    logic              w_fire;
    logic              b_fire;
    logic              w_last;
    logic [OffW-1:0]   off;
    logic [StrbW-1:0]  strb_base;

    assign req_accept = (state_q == StIdle) & cpu_aw_valid;
    assign aw_fire    = (state_q == StAddr) & axi_aw_ready_i;
    assign w_fire     = (state_q == StData) & cpu_w_valid & axi_w_ready_i;
    assign b_fire     = (state_q == StResp) & axi_b_valid_i;
    assign w_last     = (beat_cnt_q == len_q);
    assign off        = addr_q[OffW-1:0];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (cpu_aw_valid)     state_d = StAddr;
            StAddr:  if (axi_aw_ready_i)   state_d = StData;
            StData:  if (w_fire && w_last) state_d = StResp;
            StResp:  if (axi_b_valid_i)    state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Request capture, beat counting and B response capture
    always_ff @(posedge clk) begin
        if (reset) begin
            id_q       <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            size_q     <= '0;
            beat_cnt_q <= '0;
            b_valid_q  <= 1'b0;
            b_resp_q   <= 2'b00;
        end else begin
            if (req_accept) begin
                id_q   <= cpu_id;
                addr_q <= cpu_addr;
                len_q  <= cpu_len;
                size_q <= cpu_size;
            end
            if (aw_fire) begin
                beat_cnt_q <= '0;
            end else if (w_fire) begin
                beat_cnt_q <= beat_cnt_q + 1'b1;
            end
            b_valid_q <= b_fire;
            if (b_fire) begin
                b_resp_q <= b_resp_d;
            end
        end
    end

`ifdef YSYX_22041071_AXI_W_BID_CHECK_EN
    // A response for some other ID is reported to the core as a slave error.
    assign b_resp_d = (axi_b_id_i != id_q) ? 2'b10 : axi_b_resp_i;
`else
    assign b_resp_d = axi_b_resp_i;
`endif

    logic unused_ok;
    assign unused_ok = ^{axi_b_id_i, axi_b_user_i, id_q};

    always_comb begin
        strb_base = '0;
        case (size_q)
            2'b00:   strb_base = StrbW'(8'h01);
            2'b01:   strb_base = StrbW'(8'h03);
            2'b10:   strb_base = StrbW'(8'h0F);
            default: strb_base = StrbW'(8'hFF);
        endcase
    end

    // Output logic
    always_comb begin
        cpu_aw_ready    = (state_q == StIdle);
        cpu_w_ready     = (state_q == StData) & axi_w_ready_i;
        cpu_b_valid     = b_valid_q;
        cpu_b_resp      = b_resp_q;

        axi_aw_valid_o  = (state_q == StAddr);
        axi_aw_id_o     = id_q;
        axi_aw_addr_o   = {addr_q[AddrW-1:OffW], {OffW{1'b0}}};
        axi_aw_len_o    = len_q;
        axi_aw_size_o   = {1'b0, size_q};
        axi_aw_burst_o  = 2'b01;
        axi_aw_prot_o   = 3'b000;
        axi_aw_user_o   = 1'b0;
        axi_aw_lock_o   = 1'b0;
        axi_aw_cache_o  = 4'b0000;
        axi_aw_qos_o    = 4'b0000;
        axi_aw_region_o = 4'b0000;

        // Right-justified CPU data is steered to the byte lane picked by the low address bits.
        axi_w_valid_o   = (state_q == StData) & cpu_w_valid;
        axi_w_data_o    = cpu_w_data << {off, 3'b000};
        axi_w_strb_o    = strb_base << off;
        axi_w_last_o    = w_last;
        axi_w_user_o    = 1'b0;

        axi_b_ready_o   = (state_q == StResp);
    end

endmodule

// File: tb/tb_ysyx_22041071_axi_w.sv
// Directed self-checking bench for ysyx_22041071_axi_w; the bench drives the AXI slave side.

module tb_ysyx_22041071_axi_w;

    logic        clk;
    logic        reset;
    logic        cpu_aw_valid, cpu_aw_ready;
    logic [3:0]  cpu_id;
    logic [63:0] cpu_addr;
    logic [7:0]  cpu_len;
    logic [1:0]  cpu_size;
    logic        cpu_w_valid, cpu_w_ready;
    logic [63:0] cpu_w_data;
    logic        cpu_b_valid;
    logic [1:0]  cpu_b_resp;
    logic        axi_aw_valid_o, axi_aw_ready_i;
    logic [3:0]  axi_aw_id_o;
    logic [63:0] axi_aw_addr_o;
    logic [7:0]  axi_aw_len_o;
    logic [2:0]  axi_aw_size_o;
    logic [1:0]  axi_aw_burst_o;
    logic [2:0]  axi_aw_prot_o;
    logic        axi_aw_user_o, axi_aw_lock_o;
    logic [3:0]  axi_aw_cache_o, axi_aw_qos_o, axi_aw_region_o;
    logic        axi_w_valid_o, axi_w_ready_i;
    logic [63:0] axi_w_data_o;
    logic [7:0]  axi_w_strb_o;
    logic        axi_w_last_o, axi_w_user_o;
    logic        axi_b_valid_i, axi_b_ready_o;
    logic [1:0]  axi_b_resp_i;
    logic [3:0]  axi_b_id_i;
    logic        axi_b_user_i;

    int n_chk  = 0;
    int n_pass = 0;

`ifdef YSYX_22041071_AXI_W_BID_CHECK_EN
    localparam logic [1:0] BidExp = 2'b10;
`else
    localparam logic [1:0] BidExp = 2'b00;
`endif

    ysyx_22041071_axi_w dut (
        .clk             (clk),
        .reset           (reset),
        .cpu_aw_valid    (cpu_aw_valid),
        .cpu_aw_ready    (cpu_aw_ready),
        .cpu_id          (cpu_id),
        .cpu_addr        (cpu_addr),
        .cpu_len         (cpu_len),
        .cpu_size        (cpu_size),
        .cpu_w_valid     (cpu_w_valid),
        .cpu_w_ready     (cpu_w_ready),
        .cpu_w_data      (cpu_w_data),
        .cpu_b_valid     (cpu_b_valid),
        .cpu_b_resp      (cpu_b_resp),
        .axi_aw_valid_o  (axi_aw_valid_o),
        .axi_aw_ready_i  (axi_aw_ready_i),
        .axi_aw_id_o     (axi_aw_id_o),
        .axi_aw_addr_o   (axi_aw_addr_o),
        .axi_aw_len_o    (axi_aw_len_o),
        .axi_aw_size_o   (axi_aw_size_o),
        .axi_aw_burst_o  (axi_aw_burst_o),
        .axi_aw_prot_o   (axi_aw_prot_o),
        .axi_aw_user_o   (axi_aw_user_o),
        .axi_aw_lock_o   (axi_aw_lock_o),
        .axi_aw_cache_o  (axi_aw_cache_o),
        .axi_aw_qos_o    (axi_aw_qos_o),
        .axi_aw_region_o (axi_aw_region_o),
        .axi_w_valid_o   (axi_w_valid_o),
        .axi_w_ready_i   (axi_w_ready_i),
        .axi_w_data_o    (axi_w_data_o),
        .axi_w_strb_o    (axi_w_strb_o),
        .axi_w_last_o    (axi_w_last_o),
        .axi_w_user_o    (axi_w_user_o),
        .axi_b_valid_i   (axi_b_valid_i),
        .axi_b_ready_o   (axi_b_ready_o),
        .axi_b_resp_i    (axi_b_resp_i),
        .axi_b_id_i      (axi_b_id_i),
        .axi_b_user_i    (axi_b_user_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    logic [63:0] beats [4];
    int k;

    initial begin
        beats[0] = 64'h0101_0202_0303_0404;
        beats[1] = 64'h1111_2222_3333_4444;
        beats[2] = 64'hA5A5_5A5A_F00D_CAFE;
        beats[3] = 64'hDEAD_BEEF_0BAD_F00D;

        reset = 1'b1;
        cpu_aw_valid = 0; cpu_id = 0; cpu_addr = 0; cpu_len = 0; cpu_size = 0;
        cpu_w_valid = 0; cpu_w_data = 0;
        axi_aw_ready_i = 0; axi_w_ready_i = 0;
        axi_b_valid_i = 0; axi_b_resp_i = 0; axi_b_id_i = 0; axi_b_user_i = 0;
        step(); step();
        reset = 1'b0;
        cpu_w_valid = 1'b1;
        #1;
        chk("rst_aw_ready", cpu_aw_ready, 1);
        chk("rst_aw_valid", axi_aw_valid_o, 0);
        chk("rst_w_valid", axi_w_valid_o, 0);
        chk("rst_b_ready", axi_b_ready_o, 0);
        chk("rst_b_valid", cpu_b_valid, 0);
        chk("rst_b_resp", cpu_b_resp, 0);
        chk("rst_aw_addr", axi_aw_addr_o, 0);
        chk("rst_tieoffs", {axi_aw_prot_o, axi_aw_user_o, axi_aw_lock_o, axi_aw_cache_o,
                            axi_aw_qos_o, axi_aw_region_o, axi_w_user_o}, 0);
        cpu_w_valid = 1'b0;

        // Byte store at offset 5
        cpu_aw_valid = 1; cpu_id = 4'd1; cpu_addr = 64'h8000_0005; cpu_size = 2'b00; cpu_len = 0;
        axi_aw_ready_i = 1; axi_w_ready_i = 1;
        step();
        cpu_aw_valid = 0; cpu_addr = 64'h0; cpu_w_valid = 1; cpu_w_data = 64'hAB;
        #1;
        chk("b_aw_valid", axi_aw_valid_o, 1);
        chk("b_aw_addr", axi_aw_addr_o, 64'h8000_0000);
        chk("b_aw_size", axi_aw_size_o, 0);
        chk("b_aw_len", axi_aw_len_o, 0);
        chk("b_aw_burst", axi_aw_burst_o, 2'b01);
        chk("b_aw_id", axi_aw_id_o, 1);
        chk("b_cpu_aw_ready_low", cpu_aw_ready, 0);
        chk("b_no_w_in_addr", axi_w_valid_o, 0);
        step();
        chk("b_w_valid", axi_w_valid_o, 1);
        chk("b_w_data", axi_w_data_o, 64'h0000_AB00_0000_0000);
        chk("b_w_strb", axi_w_strb_o, 8'h20);
        chk("b_w_last", axi_w_last_o, 1);
        chk("b_aw_valid_low", axi_aw_valid_o, 0);
        chk("b_cpu_w_ready", cpu_w_ready, 1);
        step();
        cpu_w_valid = 0; axi_b_valid_i = 1; axi_b_resp_i = 2'b00;
        #1;
        chk("b_b_ready", axi_b_ready_o, 1);
        chk("b_w_valid_low", axi_w_valid_o, 0);
        chk("b_no_early_pulse", cpu_b_valid, 0);
        step();
        axi_b_valid_i = 0;
        #1;
        chk("b_pulse", cpu_b_valid, 1);
        chk("b_resp", cpu_b_resp, 0);
        chk("b_idle_ready", cpu_aw_ready, 1);
        step();
        chk("b_pulse_one_cycle", cpu_b_valid, 0);

        // Word store at offset 4, EXOKAY response captured
        cpu_aw_valid = 1; cpu_id = 4'd2; cpu_addr = 64'h8000_0004; cpu_size = 2'b10; cpu_len = 0;
        step();
        cpu_aw_valid = 0; cpu_w_valid = 1; cpu_w_data = 64'h1234_5678;
        step();
        chk("w_w_strb", axi_w_strb_o, 8'hF0);
        chk("w_w_data", axi_w_data_o, 64'h1234_5678_0000_0000);
        step();
        cpu_w_valid = 0; axi_b_valid_i = 1; axi_b_resp_i = 2'b01;
        step();
        axi_b_valid_i = 0; axi_b_resp_i = 2'b00;
        #1;
        chk("w_pulse", cpu_b_valid, 1);
        chk("w_resp", cpu_b_resp, 2'b01);
        step();

        // 4-beat burst with toggling wready
        cpu_aw_valid = 1; cpu_id = 4'd5; cpu_addr = 64'h8000_1000; cpu_size = 2'b11; cpu_len = 8'd3;
        step();
        cpu_aw_valid = 0;
        #1;
        chk("r_aw_len", axi_aw_len_o, 3);
        chk("r_aw_size", axi_aw_size_o, 3);
        step();
        k = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (axi_b_ready_o) break;
            axi_w_ready_i = (cyc % 2 == 1);
            cpu_w_valid = 1;
            cpu_w_data = (k < 4) ? beats[k] : 64'h0;
            #1;
            if (axi_w_valid_o && axi_w_ready_i) begin
                chk("r_w_data", axi_w_data_o, beats[k]);
                chk("r_w_last", axi_w_last_o, (k == 3));
                chk("r_w_strb", axi_w_strb_o, 8'hFF);
                k++;
            end
            step();
        end
        cpu_w_valid = 0; axi_w_ready_i = 1;
        chk("r_beat_count", k, 4);
        chk("r_in_resp", axi_b_ready_o, 1);
        axi_b_valid_i = 1;
        step();
        axi_b_valid_i = 0;
        #1;
        chk("r_pulse", cpu_b_valid, 1);
        step();

        // AW backpressure for 5 cycles
        axi_aw_ready_i = 0;
        cpu_aw_valid = 1; cpu_id = 4'd7; cpu_addr = 64'h8000_2003; cpu_size = 2'b00; cpu_len = 0;
        step();
        cpu_aw_valid = 0; cpu_addr = 64'hDEAD; cpu_id = 4'd0;
        cpu_w_valid = 1; cpu_w_data = 64'h5A;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("p_aw_valid_held", axi_aw_valid_o, 1);
            chk("p_aw_addr_stable", axi_aw_addr_o, 64'h8000_2000);
            chk("p_aw_id_stable", axi_aw_id_o, 7);
            chk("p_no_w", axi_w_valid_o, 0);
            step();
        end
        axi_aw_ready_i = 1;
        step();
        chk("p_w_strb", axi_w_strb_o, 8'h08);
        chk("p_w_data", axi_w_data_o, 64'h0000_0000_5A00_0000);
        step();
        cpu_w_valid = 0; axi_b_valid_i = 1;
        step();
        axi_b_valid_i = 0;
        #1;
        chk("p_pulse", cpu_b_valid, 1);
        step();

        // Reset in DATA after the first of four beats
        cpu_aw_valid = 1; cpu_id = 4'd2; cpu_addr = 64'h8000_3000; cpu_size = 2'b11; cpu_len = 8'd3;
        step();
        cpu_aw_valid = 0; cpu_w_valid = 1; cpu_w_data = 64'h1;
        step();
        step();
        chk("x_still_data", axi_w_valid_o, 1);
        reset = 1; axi_b_valid_i = 1;
        step();
        chk("x_aw_valid", axi_aw_valid_o, 0);
        chk("x_w_valid", axi_w_valid_o, 0);
        chk("x_b_ready", axi_b_ready_o, 0);
        chk("x_b_valid", cpu_b_valid, 0);
        chk("x_idle", cpu_aw_ready, 1);
        chk("x_fields_clear", axi_aw_addr_o, 0);
        reset = 0; axi_b_valid_i = 0; cpu_w_valid = 0;
        step();
        chk("x_no_pulse", cpu_b_valid, 0);

        // B in DATA ignored, then BID mismatch on the real response
        axi_w_ready_i = 0;
        cpu_aw_valid = 1; cpu_id = 4'd1; cpu_addr = 64'h8000_4000; cpu_size = 2'b11; cpu_len = 0;
        step();
        cpu_aw_valid = 0; cpu_w_valid = 1; cpu_w_data = 64'h77;
        step();
        axi_b_valid_i = 1; axi_b_id_i = 4'd3; axi_b_resp_i = 2'b00;
        #1;
        chk("i_b_ready_in_data", axi_b_ready_o, 0);
        chk("i_cpu_w_ready", cpu_w_ready, 0);
        step();
        chk("i_still_data", axi_w_valid_o, 1);
        chk("i_no_pulse", cpu_b_valid, 0);
        axi_w_ready_i = 1;
        step();
        cpu_w_valid = 0;
        #1;
        chk("i_in_resp", axi_b_ready_o, 1);
        step();
        axi_b_valid_i = 0; axi_b_id_i = 4'd0;
        #1;
        chk("i_pulse", cpu_b_valid, 1);
        chk("i_bid_resp", cpu_b_resp, BidExp);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
